uart_wr_arbiter: RTL

//  Two-master AXI4-Lite write arbiter and sequencer in front of the simulation UART
//  (UART TX register at 0xa000_03f8). Each master is LSU or debug-print. One write is in

---
 rtl/uart_bus_pkg.sv | 18 +
 rtl/uart_wr_arbiter_rr_arb2.sv | 14 +
 rtl/uart_wr_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/uart_bus_pkg.sv
// Shared definitions for the UART write path: AXI response codes, sequencer states
// and the simulation UART TX register address.
package uart_bus_pkg;

  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [1:0]  RESP_SLVERR  = 2'b10;
  localparam logic [1:0]  RESP_DECERR  = 2'b11;

  localparam logic [31:0] UART_TX_ADDR = 32'ha000_03f8;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_B,
    RESP
  } state_t;

endpackage

// File: rtl/uart_wr_arbiter_rr_arb2.sv
// Two-way round-robin picker, purely combinational: a lone request wins outright,
// a tie goes to the master named by ptr.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (&req) gnt = ptr ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/uart_wr_arbiter.sv
// Two-master AXI4-Lite write arbiter in front of the simulation UART: one write in flight,
// round-robin grants, DECERR answered locally for addresses outside the UART window.
module uart_wr_arbiter
  import uart_bus_pkg::*;
#(
  parameter int unsigned   AW        = 32,
  parameter int unsigned   DW        = 32,
  parameter logic [AW-1:0] UART_BASE = AW'(UART_TX_ADDR),
  parameter int unsigned   UART_SIZE = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          m_aw_valid,
  output logic [1:0]          m_aw_ready,
  input  logic [2*AW-1:0]     m_aw_addr,
  input  logic [1:0]          m_w_valid,
  output logic [1:0]          m_w_ready,
  input  logic [2*DW-1:0]     m_w_data,
  input  logic [2*(DW/8)-1:0] m_w_strb,
  output logic [1:0]          m_b_valid,
  input  logic [1:0]          m_b_ready,
  output logic [1:0]          m_b_resp,
  output logic                s_aw_valid,
  input  logic                s_aw_ready,
  output logic [AW-1:0]       s_aw_addr,
  output logic                s_w_valid,
  input  logic                s_w_ready,
  output logic [DW-1:0]       s_w_data,
  output logic [DW/8-1:0]     s_w_strb,
  input  logic                s_b_valid,
  output logic                s_b_ready,
  input  logic [1:0]          s_b_resp
);

  localparam int unsigned SW = DW / 8;

  state_t          state_q, state_d;
  logic [1:0]      elig, gnt;
  logic [AW-1:0]   sel_addr, offs, addr_q;
  logic [DW-1:0]   sel_data, data_q;
  logic [SW-1:0]   sel_strb, strb_q;
  logic            hit;
  logic            gsel_q, rr_ptr_q;
  logic [1:0]      resp_q;
  logic            aw_pend_q, w_pend_q;

  // A master only competes once both its AW and W are offered, so the pair handshakes together.
  assign elig = m_aw_valid & m_w_valid;

  rr_arb2 u_arb (
    .req (elig),
    .ptr (rr_ptr_q),
    .gnt (gnt)
  );

  assign sel_addr = gnt[1] ? m_aw_addr[2*AW-1:AW] : m_aw_addr[AW-1:0];
  assign sel_data = gnt[1] ? m_w_data[2*DW-1:DW]  : m_w_data[DW-1:0];
  assign sel_strb = gnt[1] ? m_w_strb[2*SW-1:SW]  : m_w_strb[SW-1:0];

  // Unsigned wrap makes anything below the base look huge, so it misses.
  assign offs = sel_addr - UART_BASE;
  assign hit  = offs < AW'(UART_SIZE);

  assign s_aw_valid = aw_pend_q;
  assign s_w_valid  = w_pend_q;
  assign s_aw_addr  = addr_q;
  assign s_w_data   = data_q;
  assign s_w_strb   = strb_q;

  always_comb begin
    state_d    = state_q;
    m_aw_ready = '0;
    m_w_ready  = '0;
    m_b_valid  = '0;
    m_b_resp   = '0;
    s_b_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        m_aw_ready = gnt;
        m_w_ready  = gnt;
        if (|gnt) state_d = hit ? SEND : RESP;
      end
      SEND: begin
        if ((!aw_pend_q || s_aw_ready) && (!w_pend_q || s_w_ready)) state_d = WAIT_B;
      end
      WAIT_B: begin
        s_b_ready = 1'b1;
        if (s_b_valid) state_d = RESP;
      end
      RESP: begin
        m_b_valid[gsel_q] = 1'b1;
        m_b_resp          = resp_q;
        if (m_b_ready[gsel_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      gsel_q    <= 1'b0;
      rr_ptr_q  <= 1'b0;
      resp_q    <= RESP_OKAY;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (|gnt) begin
            gsel_q    <= gnt[1];
            resp_q    <= RESP_DECERR;
            aw_pend_q <= hit;
            w_pend_q  <= hit;
            if (hit) begin
              addr_q <= sel_addr;
              data_q <= sel_data;
              strb_q <= sel_strb;
            end
          end
        end
        SEND: begin
          if (s_aw_ready) aw_pend_q <= 1'b0;
          if (s_w_ready)  w_pend_q  <= 1'b0;
        end
        WAIT_B: begin
          if (s_b_valid) resp_q <= s_b_resp;
        end
        RESP: begin
          if (m_b_ready[gsel_q]) rr_ptr_q <= ~gsel_q;
        end
        default: ;
      endcase
    end
  end

endmodule
